// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS core.
// Steps each instruction through fetch/decode/execute/memory/writeback
// states, sharing one memory port and one ALU across those cycles.
// Outputs are decoded from the current state; FETCH additionally gates
// irwrite/pcwrite with mem_ready so the IR and PC load only on completion.
module mc_ctrl_fsm #(
  // 1: stay in DECODE flagging illegal_op until reset; 0: one-cycle pulse, back to FETCH
  parameter bit NONE_ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwrite_cond,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_zero,
  output logic [3:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_LUI   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;

  state_t state_q, state_d;

  // Immediate-class ALU control {ext_zero, aluop}; only the low opcode bits
  // differ within the 001xxx group, so only those are decoded.
  function automatic logic [4:0] imm_ctrl(input logic [2:0] sel);
    case (sel)
      3'b000, 3'b001: imm_ctrl = {1'b0, ALU_ADD};
      3'b010:         imm_ctrl = {1'b0, ALU_SLT};
      3'b011:         imm_ctrl = {1'b0, ALU_SLTU};
      3'b100:         imm_ctrl = {1'b1, ALU_AND};
      3'b101:         imm_ctrl = {1'b1, ALU_OR};
      3'b110:         imm_ctrl = {1'b1, ALU_XOR};
      default:        imm_ctrl = {1'b0, ALU_LUI};
    endcase
  endfunction

  // State register; async reset forces IDLE so every output drops at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and output decode; everything defaults to 0 / hold state.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcwrite_cond = 1'b0;
    pcsrc        = 2'b00;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    ext_zero     = 1'b0;
    aluop        = ALU_ADD;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut while decoding
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          6'b001000, 6'b001001, 6'b001010, 6'b001011,
          6'b001100, 6'b001101, 6'b001110, 6'b001111: state_d = S_IMMEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = NONE_ILLEGAL_TRAP ? S_DECODE : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca      = 1'b1;
        aluop        = ALU_SUB;
        pcwrite_cond = 1'b1;
        pcsrc        = 2'b01;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_IMMEX: begin
        alusrca             = 1'b1;
        alusrcb             = 2'b10;
        {ext_zero, aluop}   = imm_ctrl(op[2:0]);
        state_d             = S_IMMWB;
      end
      S_IMMWB: begin
        // ALU control held so the result stays valid through writeback
        {ext_zero, aluop}   = imm_ctrl(op[2:0]);
        regwrite            = 1'b1;
        instr_done          = 1'b1;
        state_d             = S_FETCH;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule
